// File: rtl/cpu_trace_pkg.sv
// Shared widths, trace_status bit map and entry layout for the 68k bus tracer.
package cpu_trace_pkg;
  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W     = 24;
  localparam int FC_W       = 3;
  localparam int DATA_W     = 16;
  localparam int TS_W       = 16;
  localparam int CNT_W      = 7;
  localparam int OVF_W      = 8;

  localparam int ST_CNT_LSB = 0;
  localparam int ST_EMPTY   = 8;
  localparam int ST_FULL    = 9;
  localparam int ST_BP_HIT  = 10;
  localparam int ST_OVF_LSB = 16;

  typedef struct packed {
    logic [FC_W-1:0]   fc;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

  typedef enum logic [0:0] { BUS_IDLE, BUS_CYCLE } bus_state_e;

  function automatic logic [31:0] pack_head0(input trace_entry_t e);
    return {e.fc, e.rw, 4'b0, e.addr};
  endfunction

  function automatic logic [31:0] pack_head1(input trace_entry_t e);
    return {e.ts, e.data};
  endfunction

  function automatic logic [31:0] pack_status(input logic [CNT_W-1:0] cnt, input logic empty,
                                              input logic full, input logic bp_hit,
                                              input logic [OVF_W-1:0] ovf);
    logic [31:0] s;
    s = '0;
    s[ST_CNT_LSB +: CNT_W] = cnt;
    s[ST_EMPTY]            = empty;
    s[ST_FULL]             = full;
    s[ST_BP_HIT]           = bp_hit;
    s[ST_OVF_LSB +: OVF_W] = ovf;
    return s;
  endfunction
endpackage

// File: rtl/cpu_bus_trace_if.sv
// 68k bus signals as seen by the tracer; master = CPU side, slave = observer.
interface cpu_bus_trace_if;
  import cpu_trace_pkg::*;
  logic              cpu_as_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [FC_W-1:0]   cpu_fc;
  logic              cpu_rw;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_clken;

  modport master (output cpu_as_n, cpu_addr, cpu_fc, cpu_rw, cpu_din, cpu_dout, cpu_clken);
  modport slave  (input  cpu_as_n, cpu_addr, cpu_fc, cpu_rw, cpu_din, cpu_dout, cpu_clken);
endinterface

// File: rtl/cpu_bus_trace_fifo.sv
// Synchronous trace FIFO with a registered head entry (zero when empty).
module trace_fifo import cpu_trace_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  trace_entry_t     wdata,
  output trace_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk_sys)
    if (do_push && !clear) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk_sys) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // head tracks the post-edge head so the outputs stay purely registered
      if (do_pop)
        head <= (count == CNT_W'(1)) ? (do_push ? wdata : '0) : mem[rd_nxt];
      else if (empty && do_push)
        head <= wdata;
    end
  end
endmodule

// File: rtl/cpu_bus_trace.sv
// Captures one entry per 68k bus cycle (AS_n fall..rise) into a trace FIFO, with breakpoint.
module cpu_bus_trace import cpu_trace_pkg::*; #(
  parameter int          DEPTH      = DEPTH_DEF,
  parameter logic [31:0] CYCLE_INIT = 32'h0   // reset value of cycle_count (0 in normal use)
) (
  input  logic              clk_sys,
  input  logic              reset,
  cpu_bus_trace_if.slave    bus,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              pop,
  input  logic              clear,
  output logic [31:0]       trace_head0,
  output logic [31:0]       trace_head1,
  output logic [31:0]       trace_status,
  output logic [31:0]       cycle_count,
  output logic              bp_halt
);
  bus_state_e        state_q, state_d;
  logic              as_n_1, bus_ok, fall, rise, push;
  logic [ADDR_W-1:0] lat_addr;
  logic [FC_W-1:0]   lat_fc;
  logic              lat_rw, lat_bp, bp_hit;
  logic [TS_W-1:0]   lat_ts;
  logic [OVF_W-1:0]  ovf;
  logic [31:0]       cyc;
  trace_entry_t      wdata, head;
  logic [CNT_W-1:0]  count;
  logic              empty, full;

  // bus_ok blocks a false falling edge when reset releases with AS_n already low
  assign fall = bus_ok & as_n_1 & ~bus.cpu_as_n;
  assign rise = ~as_n_1 & bus.cpu_as_n;

  always_ff @(posedge clk_sys)
    if (reset) state_q <= BUS_IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      BUS_IDLE:  if (fall) state_d = BUS_CYCLE;
      BUS_CYCLE: if (rise) begin
        state_d = BUS_IDLE;
        push    = 1'b1;
      end
      default:   state_d = BUS_IDLE;
    endcase
    if (clear) begin
      state_d = BUS_IDLE;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      as_n_1   <= 1'b1;
      bus_ok   <= bus.cpu_as_n;
      lat_addr <= '0;
      lat_fc   <= '0;
      lat_rw   <= 1'b0;
      lat_ts   <= '0;
      lat_bp   <= 1'b0;
      bp_hit   <= 1'b0;
      bp_halt  <= 1'b0;
      ovf      <= '0;
      cyc      <= CYCLE_INIT;
    end else begin
      as_n_1  <= bus.cpu_as_n;
      bus_ok  <= bus_ok | bus.cpu_as_n;
      if (fall) begin
        lat_addr <= bus.cpu_addr;
        lat_fc   <= bus.cpu_fc;
        lat_rw   <= bus.cpu_rw;
        lat_ts   <= cyc[TS_W-1:0];
        lat_bp   <= bp_en & (bus.cpu_addr == bp_addr);
      end
      bp_halt <= push & lat_bp & bp_en;
      if (bus.cpu_clken) cyc <= cyc + 32'd1;
      if (clear) begin
        bp_hit <= 1'b0;
        ovf    <= '0;
      end else begin
        if (fall && bp_en && (bus.cpu_addr == bp_addr)) bp_hit <= 1'b1;
        if (push && full && !pop && (ovf != '1)) ovf <= ovf + OVF_W'(1);
      end
    end
  end

  always_comb begin
    wdata      = '0;
    wdata.fc   = lat_fc;
    wdata.rw   = lat_rw;
    wdata.addr = lat_addr;
    wdata.ts   = lat_ts;
    wdata.data = lat_rw ? bus.cpu_din : bus.cpu_dout;
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .wdata   (wdata),
    .head    (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  assign trace_head0  = pack_head0(head);
  assign trace_head1  = pack_head1(head);
  assign trace_status = pack_status(count, empty, full, bp_hit, ovf);
  assign cycle_count  = cyc;
endmodule

// File: tb/tb_cpu_bus_trace.sv
// Directed bench for cpu_bus_trace: queue scoreboard of expected head entries and status.
module tb_cpu_bus_trace;
  localparam int DEPTH = 16;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        bp_en   = 1'b0;
  logic        pop     = 1'b0;
  logic        clear   = 1'b0;
  logic [23:0] bp_addr = '0;
  logic [31:0] trace_head0, trace_head1, trace_status, cycle_count;
  logic [31:0] w_head0, w_head1, w_status, w_cycle;
  logic        bp_halt, w_halt;

  cpu_bus_trace_if bus ();

  cpu_bus_trace #(.DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus), .bp_en(bp_en), .bp_addr(bp_addr),
    .pop(pop), .clear(clear), .trace_head0(trace_head0), .trace_head1(trace_head1),
    .trace_status(trace_status), .cycle_count(cycle_count), .bp_halt(bp_halt)
  );

  cpu_bus_trace #(.DEPTH(DEPTH), .CYCLE_INIT(32'hFFFF_FFFF)) dut_w (
    .clk_sys(clk_sys), .reset(reset), .bus(bus), .bp_en(bp_en), .bp_addr(bp_addr),
    .pop(pop), .clear(clear), .trace_head0(w_head0), .trace_head1(w_head1),
    .trace_status(w_status), .cycle_count(w_cycle), .bp_halt(w_halt)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] sb [$];          // {head0, head1} expected, oldest first
  logic [7:0]  m_ovf  = '0;
  logic        m_bp   = 1'b0;
  logic [31:0] m_cyc  = '0;
  int          m_halt = 0;
  int          halt_cnt = 0;

  always @(posedge clk_sys)
    if (reset)              m_cyc <= '0;
    else if (bus.cpu_clken) m_cyc <= m_cyc + 32'd1;

  always @(negedge clk_sys)
    if (bp_halt) halt_cnt <= halt_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int n;
    n = sb.size();
    return {8'h0, m_ovf, 5'b0, m_bp, n == DEPTH, n == 0, 1'b0, 7'(n)};
  endfunction

  task automatic check_fifo(input string tag);
    logic [63:0] e;
    e = '0;
    if (sb.size() > 0) e = sb[0];
    check({tag, ".status"},   trace_status, exp_status());
    check({tag, ".w_status"}, w_status,     exp_status());
    check({tag, ".head0"},    trace_head0,  e[63:32]);
    check({tag, ".head1"},    trace_head1,  e[31:0]);
    check({tag, ".cycle"},    cycle_count,  m_cyc);
  endtask

  task automatic bus_cycle(input logic [23:0] a, input logic [2:0] fc, input logic rw,
                           input logic [15:0] d, input logic pop_r, input logic clr_r);
    logic [15:0] ts;
    logic        exp_halt;
    @(negedge clk_sys);
    bus.cpu_addr = a;
    bus.cpu_fc   = fc;
    bus.cpu_rw   = rw;
    bus.cpu_din  = rw ? d : ~d;
    bus.cpu_dout = rw ? ~d : d;
    bus.cpu_as_n = 1'b0;
    ts = m_cyc[15:0];
    repeat (2) @(negedge clk_sys);
    bus.cpu_as_n = 1'b1;
    pop   = pop_r;
    clear = clr_r;
    exp_halt = bp_en && (a == bp_addr) && !clr_r;
    @(negedge clk_sys);
    pop   = 1'b0;
    clear = 1'b0;
    if (clr_r) begin
      sb.delete();
      m_ovf = '0;
      m_bp  = 1'b0;
    end else begin
      if (bp_en && a == bp_addr) m_bp = 1'b1;
      if (pop_r && sb.size() > 0) void'(sb.pop_front());
      if (sb.size() < DEPTH) sb.push_back({fc, rw, 4'b0, a, ts, d});
      else if (m_ovf != 8'hFF) m_ovf++;
      if (exp_halt) m_halt++;
    end
    check("halt_at_rise", {31'b0, bp_halt}, {31'b0, exp_halt});
  endtask

  task automatic do_pop();
    @(negedge clk_sys) pop = 1'b1;
    @(negedge clk_sys) pop = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic do_clear();
    @(negedge clk_sys) clear = 1'b1;
    @(negedge clk_sys) clear = 1'b0;
    sb.delete();
    m_ovf = '0;
    m_bp  = 1'b0;
  endtask

  initial begin
    bus.cpu_as_n  = 1'b1;
    bus.cpu_addr  = '0;
    bus.cpu_fc    = '0;
    bus.cpu_rw    = 1'b1;
    bus.cpu_din   = '0;
    bus.cpu_dout  = '0;
    bus.cpu_clken = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;

    check_fifo("reset");
    check("reset.bp_halt", {31'b0, bp_halt}, 32'h0);
    check("reset.w_cycle", w_cycle, 32'hFFFF_FFFF);

    // stopped CPU clock freezes the counter; one enabled clock wraps the preloaded one
    repeat (10) @(negedge clk_sys);
    check("frozen.cycle",   cycle_count, 32'h0);
    check("frozen.w_cycle", w_cycle,     32'hFFFF_FFFF);
    bus.cpu_clken = 1'b1;
    @(negedge clk_sys);
    check("wrap.w_cycle", w_cycle,     32'h0);
    check("wrap.cycle",   cycle_count, 32'h1);

    // reset in the middle of a bus cycle: the closing AS_n rise pushes nothing
    @(negedge clk_sys);
    bus.cpu_addr = 24'h123456;
    bus.cpu_as_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    bus.cpu_as_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    check_fifo("rst_mid");

    bus_cycle(24'h00FC00, 3'd6, 1'b1, 16'h4E71, 1'b0, 1'b0);
    check_fifo("read");
    check("read.head0_lit", trace_head0, 32'hD000_FC00);
    do_pop();
    check_fifo("pop1");
    do_pop();
    check_fifo("pop_empty");

    for (int i = 0; i < 17; i++)
      bus_cycle(24'h001000 + 24'(2 * i), 3'd5, 1'b0, 16'hA000 + 16'(i), 1'b0, 1'b0);
    check_fifo("overflow");
    check("overflow.status_lit", trace_status, 32'h0001_0210);

    do_clear();
    check_fifo("clear");
    for (int i = 0; i < 16; i++)
      bus_cycle(24'h002000 + 24'(2 * i), 3'd1, 1'b0, 16'hB000 + 16'(i), 1'b0, 1'b0);
    check_fifo("full");
    bus_cycle(24'h003000, 3'd2, 1'b1, 16'hC0DE, 1'b1, 1'b0);
    check_fifo("push_pop_full");

    do_clear();
    bp_en   = 1'b1;
    bp_addr = 24'h000400;
    bus_cycle(24'h000400, 3'd6, 1'b1, 16'h1234, 1'b0, 1'b0);
    check_fifo("bp_match");
    bus_cycle(24'h000402, 3'd6, 1'b1, 16'h5678, 1'b0, 1'b0);
    check_fifo("bp_miss");
    @(negedge clk_sys);
    check("bp.halt_pulses", halt_cnt, m_halt);

    bp_en = 1'b0;
    bus_cycle(24'h004000, 3'd5, 1'b0, 16'h55AA, 1'b0, 1'b1);
    check_fifo("clr_push");
    do_pop();
    check_fifo("clr_pop_empty");
    check("clr_pop_empty.status_lit", trace_status, 32'h0000_0100);
    check("final.halt_pulses", halt_cnt, m_halt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_bus_trace.md
CPU_BUS_TRACE -- requirements
Module: cpu_bus_trace

Interface
REQ-001 SHALL have parameter DEPTH, default 16, trace FIFO entries (power of two, 4..64).
REQ-002 SHALL have port clk_sys  input  1  core clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_as_n  input  1  68k address strobe, active low.
REQ-005 SHALL have port cpu_addr  input  24  68k byte address.
REQ-006 SHALL have port cpu_fc  input  3  68k function code.
REQ-007 SHALL have port cpu_rw  input  1  1 = read, 0 = write.
REQ-008 SHALL have port cpu_din  input  16  data into CPU (read data).
REQ-009 SHALL have port cpu_dout  input  16  data out of CPU (write data).
REQ-010 SHALL have port cpu_clken  input  1  gated CPU clock enable (debug-stopped when 0).
REQ-011 SHALL have port bp_en  input  1  breakpoint enable.
REQ-012 SHALL have port bp_addr  input  24  breakpoint address.
REQ-013 SHALL have port pop  input  1  one-cycle strobe: discard head entry.
REQ-014 SHALL have port clear  input  1  one-cycle strobe: flush FIFO, clear bp_hit and overflow.
REQ-015 SHALL have port trace_head0  output  32  {fc[2:0], rw, 4'b0, addr[23:0]} of head entry.
REQ-016 SHALL have port trace_head1  output  32  {timestamp[15:0], data[15:0]} of head entry.
REQ-017 SHALL have port trace_status  output  32  [6:0] count, [8] empty, [9] full, [10] bp_hit, [23:16] overflow; other bits 0.
REQ-018 SHALL have port cycle_count  output  32  free-running count of clocks with cpu_clken=1.
REQ-019 SHALL have port bp_halt  output  1  one-cycle pulse requesting a halt at end of the matching bus cycle.

Function
REQ-020 SHALL register cpu_as_n once (as_n_1); falling edge = as_n_1 & !cpu_as_n, rising edge = !as_n_1 & cpu_as_n.
REQ-021 SHALL latch cpu_addr, cpu_fc, cpu_rw and cycle_count[15:0] on the clock a falling edge is detected.
REQ-022 SHALL, on a detected rising edge, push one entry: latched fields plus data = cpu_din if latched rw=1, else cpu_dout.
REQ-023 SHALL ignore a rising edge with no preceding falling edge since reset/clear (no push).
REQ-024 SHALL update count/empty/full on the push clock; trace_head0/1 valid in the same cycle empty reads 0.
REQ-025 SHALL, on push while full and no pop, drop the entry and increment overflow, saturating at 255.
REQ-026 SHALL, on push and pop in the same cycle, perform both (count unchanged), including when full.
REQ-027 SHALL ignore pop when empty; trace_head0/1 SHALL read 32'h0 when empty.
REQ-028 SHALL give clear priority over push and pop in the same cycle; the push is lost, not counted as overflow.
REQ-029 SHALL increment cycle_count by 1 every clock with cpu_clken=1, wrapping 32'hFFFFFFFF to 0; clear does not reset it.
REQ-030 SHALL set bp_hit (sticky until clear/reset) when bp_en=1 and latched address == bp_addr at the falling edge.
REQ-031 SHALL pulse bp_halt for exactly one clock at the rising edge ending a matching cycle; none if bp_en drops mid-cycle.
REQ-032 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-033 SHALL on reset: FIFO empty, count 0, overflow 0, bp_hit 0, bp_halt 0, cycle_count 0, as_n_1 = 1, latched fields 0.
REQ-034 SHALL discard any bus cycle in progress when reset asserts mid-cycle; the next rising edge pushes nothing.

Structure
REQ-035 SHALL place DEPTH default, entry field widths, and trace_status bit positions in shared package cpu_trace_pkg.
REQ-036 SHALL implement storage as one sub-module trace_fifo (synchronous FIFO, registered head, push/pop/clear, count).

Verification
REQ-037 SHALL cover: read cycle addr 0x00FC00, fc=6, din 0x4E71 -> head0 0xD000FC00 (fc=6, rw=1), head1[15:0]=0x4E71, count 1.
REQ-038 SHALL cover: 17 write cycles with DEPTH=16, no pop -> count 16, full 1, overflow 1; head is the first entry.
REQ-039 SHALL cover: full FIFO, push+pop same clock -> count stays 16, overflow stays 0, head advances one entry.
REQ-040 SHALL cover: bp_en=1, bp_addr 0x000400, cycle to 0x000400 -> bp_hit 1, one bp_halt pulse at AS_n rise; 0x000402 -> no pulse.
REQ-041 SHALL cover: clear with push same clock, then pop when empty -> empty 1, count 0, overflow 0, head0/head1 = 0.
REQ-042 SHALL cover: cpu_clken low 10 clocks -> cycle_count frozen; preload 32'hFFFFFFFF, one enabled clock -> 0.
